// File: rtl/iomem_wb_pkg.sv
// Shared types and constants for the picosoc iomem to Wishbone bridge.
// Imported by the bridge FSM and its timeout watchdog.
package iomem_wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        HOLD
    } state_t;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    localparam int SLV_LEDS = 0;
    localparam int SLV_VGA  = 1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_timeout_watchdog.sv
// Bus watchdog: counts REQ cycles, flags expiry, keeps a saturating
// count of timeouts that err_clr resets (a same-cycle timeout wins).
module wb_timeout_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_run,
    input  logic       i_ack,
    input  logic       i_clr,
    output logic       o_expire,
    output logic [7:0] o_timeout_cnt
);
    import iomem_wb_pkg::*;

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] r_wd;
    logic [7:0]    r_tcnt;
    logic          w_last;

    assign w_last        = (r_wd == CW'(TIMEOUT_CYCLES - 1));
    assign o_expire      = i_run && !i_ack && w_last;
    assign o_timeout_cnt = r_tcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd <= '0;
        end else if (i_start) begin
            r_wd <= '0;
        end else if (i_run) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt <= 8'd0;
        end else if (o_expire) begin
            if (i_clr) begin
                r_tcnt <= 8'd1;
            end else if (r_tcnt != 8'hFF) begin
                r_tcnt <= r_tcnt + 8'd1;
            end
        end else if (i_clr) begin
            r_tcnt <= 8'd0;
        end
    end

endmodule

// File: rtl/iomem_wb_bridge.sv
// picosoc iomem to multi-slave Wishbone classic bridge with address
// decode, one-hot cycle select, indexed read mux and bus watchdog.
module iomem_wb_bridge
    import iomem_wb_pkg::*;
#(
    parameter int          NUM_SLAVES     = 4,
    parameter logic [7:0]  WB_BASE        = 8'h03,
    parameter int          SEL_LSB        = 20,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     iomem_valid,
    output logic                     iomem_ready,
    input  logic [3:0]               iomem_wstrb,
    input  logic [31:0]              iomem_addr,
    input  logic [31:0]              iomem_wdata,
    output logic [31:0]              iomem_rdata,
    output logic [NUM_SLAVES-1:0]    wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    output logic [3:0]               wb_sel_o,
    output logic [31:0]              wb_adr_o,
    output logic [31:0]              wb_dat_o,
    input  logic [NUM_SLAVES-1:0]    wb_ack_i,
    input  logic [32*NUM_SLAVES-1:0] wb_dat_i,
    output logic                     err_o,
    input  logic                     err_clr,
    output logic [7:0]               timeout_cnt
);
    localparam int IDX_W = idx_width(NUM_SLAVES);

    state_t                r_state, w_state_nx;
    logic [NUM_SLAVES-1:0] r_cyc, w_cyc_nx;
    logic                  r_stb, w_stb_nx;
    logic                  r_we, w_we_nx;
    logic [3:0]            r_sel, w_sel_nx;
    logic [31:0]           r_adr, w_adr_nx;
    logic [31:0]           r_dat, w_dat_nx;
    logic [31:0]           r_rdata, w_rdata_nx;
    logic [IDX_W-1:0]      r_idx, w_idx_nx;
    logic                  r_err, w_err_nx;

    logic [IDX_W-1:0] w_idx_in;
    logic             w_in_win;
    logic             w_dec_ok;
    logic             w_start;
    logic             w_run;
    logic             w_ack;
    logic [31:0]      w_slv_dat;
    logic             w_expire;

    assign w_idx_in = iomem_addr[SEL_LSB +: IDX_W];
    assign w_in_win = (iomem_addr[31:24] >= WB_BASE);
    assign w_dec_ok = (int'(w_idx_in) < NUM_SLAVES);
    assign w_run    = (r_state == REQ);
    assign w_start  = (r_state == IDLE) && iomem_valid
                   && w_in_win && w_dec_ok;

    // Only the addressed slave's ack and data are looked at
    always_comb begin
        w_ack     = 1'b0;
        w_slv_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(r_idx) == i) begin
                w_ack     = wb_ack_i[i];
                w_slv_dat = wb_dat_i[32*i +: 32];
            end
        end
    end

    wb_timeout_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk           (clk),
        .reset         (reset),
        .i_start       (w_start),
        .i_run         (w_run),
        .i_ack         (w_ack),
        .i_clr         (err_clr),
        .o_expire      (w_expire),
        .o_timeout_cnt (timeout_cnt)
    );

    always_comb begin
        w_state_nx = r_state;
        w_cyc_nx   = r_cyc;
        w_stb_nx   = r_stb;
        w_we_nx    = r_we;
        w_sel_nx   = r_sel;
        w_adr_nx   = r_adr;
        w_dat_nx   = r_dat;
        w_rdata_nx = r_rdata;
        w_idx_nx   = r_idx;
        w_err_nx   = err_clr ? 1'b0 : r_err;
        unique case (r_state)
            IDLE: begin
                if (iomem_valid && w_in_win) begin
                    w_adr_nx = iomem_addr;
                    w_dat_nx = iomem_wdata;
                    w_sel_nx = iomem_wstrb;
                    w_we_nx  = |iomem_wstrb;
                    w_idx_nx = w_idx_in;
                    if (w_dec_ok) begin
                        for (int i = 0; i < NUM_SLAVES; i++) begin
                            w_cyc_nx[i] = (int'(w_idx_in) == i);
                        end
                        w_stb_nx   = 1'b1;
                        w_state_nx = REQ;
                    end else begin
                        w_rdata_nx = ERR_DATA;
                        w_err_nx   = 1'b1;
                        w_state_nx = RESP;
                    end
                end
            end
            REQ: begin
                if (w_ack) begin
                    w_rdata_nx = w_slv_dat;
                    w_cyc_nx   = '0;
                    w_stb_nx   = 1'b0;
                    w_we_nx    = 1'b0;
                    w_state_nx = RESP;
                end else if (w_expire) begin
                    w_rdata_nx = ERR_DATA;
                    w_err_nx   = 1'b1;
                    w_cyc_nx   = '0;
                    w_stb_nx   = 1'b0;
                    w_we_nx    = 1'b0;
                    w_state_nx = RESP;
                end
            end
            RESP:    w_state_nx = HOLD;
            HOLD:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cyc   <= '0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 4'd0;
            r_adr   <= 32'd0;
            r_dat   <= 32'd0;
            r_rdata <= 32'd0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cyc   <= w_cyc_nx;
            r_stb   <= w_stb_nx;
            r_we    <= w_we_nx;
            r_sel   <= w_sel_nx;
            r_adr   <= w_adr_nx;
            r_dat   <= w_dat_nx;
            r_rdata <= w_rdata_nx;
            r_idx   <= w_idx_nx;
            r_err   <= w_err_nx;
        end
    end

    assign iomem_ready = (r_state == RESP);
    assign iomem_rdata = r_rdata;
    assign wb_cyc_o    = r_cyc;
    assign wb_stb_o    = r_stb;
    assign wb_we_o     = r_we;
    assign wb_sel_o    = r_sel;
    assign wb_adr_o    = r_adr;
    assign wb_dat_o    = r_dat;
    assign err_o       = r_err;

endmodule

// File: tb/tb_iomem_wb_bridge.sv
// Randomized transaction-level bench for iomem_wb_bridge with a
// timing/result reference model and a reactive Wishbone slave.
module tb_iomem_wb_bridge;

    localparam int          NS   = 3;
    localparam int          TO   = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          iomem_valid;
    logic          iomem_ready;
    logic [3:0]    iomem_wstrb;
    logic [31:0]   iomem_addr;
    logic [31:0]   iomem_wdata;
    logic [31:0]   iomem_rdata;
    logic [NS-1:0] wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [3:0]    wb_sel_o;
    logic [31:0]   wb_adr_o;
    logic [31:0]   wb_dat_o;
    logic [NS-1:0] wb_ack_i;
    logic [32*NS-1:0] wb_dat_i;
    logic          err_o;
    logic          err_clr;
    logic [7:0]    timeout_cnt;

    int n_vec = 0;
    int n_bad = 0;
    bit m_err = 1'b0;
    int m_tcnt = 0;

    always #5 clk = ~clk;

    iomem_wb_bridge #(
        .NUM_SLAVES     (NS),
        .WB_BASE        (8'h03),
        .SEL_LSB        (20),
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (ERRD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_i    (wb_ack_i),
        .wb_dat_i    (wb_dat_i),
        .err_o       (err_o),
        .err_clr     (err_clr),
        .timeout_cnt (timeout_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a negedge. w = slave wait cycles after cyc is
    // seen (>= TO means the slave answers too late or never).
    task automatic run_txn(input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input int w,
                           input logic [31:0] ack_dat, input bit clr_hit);
        bit          in_win, dec_ok, tmo, cyc_on;
        int          idx, exp_n, last;
        logic [31:0] exp_rd, got_rd;
        in_win = (a[31:24] >= 8'h03);
        idx    = int'(a[21:20]);
        dec_ok = (idx < NS);
        tmo    = in_win && dec_ok && (w >= TO);
        if (!in_win)      exp_n = -1;
        else if (!dec_ok) exp_n = 0;
        else if (tmo)     exp_n = TO;
        else              exp_n = w + 1;
        exp_rd = (!dec_ok || tmo) ? ERRD : ack_dat;
        last   = in_win ? exp_n + 2 : 8;
        got_rd = 32'h0;
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            cyc_on = in_win && dec_ok && (i < exp_n);
            chk("ready", iomem_ready, i == exp_n);
            chk("cyc", wb_cyc_o, cyc_on ? (1 << idx) : 0);
            chk("stb", wb_stb_o, cyc_on);
            if (cyc_on) begin
                chk("adr", wb_adr_o, a);
                chk("wdat", wb_dat_o, d);
                chk("sel", wb_sel_o, s);
                chk("we", wb_we_o, s != 4'd0);
            end
            if (iomem_ready) begin
                got_rd      = iomem_rdata;
                iomem_valid = 1'b0;
            end
            wb_dat_i = {$urandom, $urandom, $urandom};
            wb_ack_i = NS'($urandom) & ~(NS'(1) << idx);
            if (cyc_on && i == w) begin
                wb_ack_i[idx]         = 1'b1;
                wb_dat_i[32*idx +: 32] = ack_dat;
            end
            err_clr = clr_hit && (i == exp_n - 1);
        end
        iomem_valid = 1'b0;
        err_clr     = 1'b0;
        wb_ack_i    = '0;
        if (in_win) chk("rdata", got_rd, exp_rd);
        if (clr_hit && in_win && dec_ok) begin
            m_err  = 1'b0;
            m_tcnt = 0;
        end
        if (in_win && !dec_ok) m_err = 1'b1;
        if (tmo) begin
            m_err  = 1'b1;
            m_tcnt = (m_tcnt < 255) ? m_tcnt + 1 : 255;
        end
        chk("err", err_o, m_err);
        chk("tcnt", timeout_cnt, m_tcnt);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err   = 1'b0;
        m_tcnt  = 0;
        chk("clr_err", err_o, m_err);
        chk("clr_tcnt", timeout_cnt, m_tcnt);
    endtask

    task automatic reset_mid();
        int nr;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0010;
        iomem_wstrb = 4'd0;
        iomem_wdata = 32'h0;
        wb_ack_i    = '0;
        repeat (3) @(negedge clk);
        chk("rst_pre_cyc", wb_cyc_o, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_rdy", iomem_ready, 0);
        reset       = 1'b0;
        iomem_valid = 1'b0;
        m_err       = 1'b0;
        m_tcnt      = 0;
        nr          = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (iomem_ready || wb_cyc_o != '0) nr++;
        end
        chk("rst_quiet", nr, 0);
        chk("rst_err", err_o, m_err);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        int          r, w;
        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        wb_ack_i    = '0;
        wb_dat_i    = '0;
        err_clr     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", iomem_ready, 0);
        chk("rst_rdata", iomem_rdata, 0);
        chk("rst_cyc0", wb_cyc_o, 0);
        chk("rst_stb0", wb_stb_o, 0);
        chk("rst_we0", wb_we_o, 0);
        chk("rst_sel0", wb_sel_o, 0);
        chk("rst_adr0", wb_adr_o, 0);
        chk("rst_dat0", wb_dat_o, 0);
        chk("rst_err0", err_o, 0);
        chk("rst_tcnt0", timeout_cnt, 0);
        reset = 1'b0;
        @(negedge clk);

        run_txn(32'h0310_0004, 4'b0000, 32'h0, 3, 32'h1234_5678, 1'b0);
        run_txn(32'h0300_0000, 4'b0011, 32'hAABB_CCDD, 0,
                $urandom, 1'b0);
        run_txn(32'h0330_0000, 4'b0000, 32'h0, 0, 32'h0, 1'b0);
        pulse_clr();
        run_txn(32'h0300_0100, 4'b0000, 32'h0, 99, 32'h0, 1'b0);
        pulse_clr();
        run_txn(32'h0300_0200, 4'b0000, 32'h0, TO - 1, 32'hCAFE_F00D,
                1'b0);
        run_txn(32'h0300_0300, 4'b0000, 32'h0, 99, 32'h0, 1'b1);
        run_txn(32'h0200_0000, 4'b1111, 32'h5555_AAAA, 0, 32'h0, 1'b0);
        reset_mid();

        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 9);
            a = $urandom;
            if (r == 0) a[31:24] = 8'($urandom_range(0, 2));
            else        a[31:24] = 8'($urandom_range(3, 255));
            if (r == 1)     a[21:20] = 2'd3;
            else if (r > 1) a[21:20] = 2'($urandom_range(0, 2));
            s = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            r = $urandom_range(0, 9);
            if (r <= 5)      w = $urandom_range(0, 5);
            else if (r == 6) w = TO - 1;
            else if (r == 7) w = TO;
            else             w = 99;
            run_txn(a, s, $urandom, w, $urandom,
                    $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) pulse_clr();
        end

        pulse_clr();
        for (int t = 0; t < 257; t++) begin
            run_txn(32'h0310_0000 | 32'($urandom_range(0, 255)), 4'd0,
                    32'h0, 99, 32'h0, 1'b0);
        end
        chk("tcnt_sat", timeout_cnt, 255);
        pulse_clr();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
